io_port_unit: RTL

- Buffers the processor's 16-bit I/O ports against external devices that use valid/ready handshakes.
- Input side: external producer words are queued in a FIFO. The head word is presented to the processor input port, and the FIFO pops when an IN instruction consumes it.
- Output side: words written by OUT instructions at write-back are queued in a FIFO and drained to an external consumer.
- Sits beside the processor top level, directly upstream of its input port and downstream of its output port.

---
 rtl/io_pkg.sv | 11 +
 rtl/port_fifo.sv | 67 ++++++
 rtl/io_port_unit.sv | 100 ++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the processor I/O port buffering unit.
package io_pkg;

  localparam int unsigned DATA_W = 16;

  // Occupancy needs one bit more than the pointer so that DEPTH itself is representable.
  function automatic int unsigned cntW(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/port_fifo.sv
// Registered-storage FIFO with a combinational head and a register holding the
// word most recently popped.
module port_fifo
  import io_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         dataIn,
  output logic [WIDTH-1:0]         head,
  output logic [WIDTH-1:0]         lastPopped,
  output logic [cntW(DEPTH)-1:0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = cntW(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  always_comb begin
    full   = (count == CW'(DEPTH));
    empty  = (count == '0);
    doPop  = pop && !empty;
    // A push into a full FIFO is legal when the head leaves on the same edge.
    doPush = push && (!full || doPop);
    head   = mem[rdPtr];
  end

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= dataIn;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      count      <= '0;
      lastPopped <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + AW'(1);
      end
      if (doPop) begin
        rdPtr      <= rdPtr + AW'(1);
        lastPopped <= mem[rdPtr];
      end
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_port_unit.sv
// Buffers the processor's I/O ports against valid/ready external devices:
// an input FIFO feeding in_port and an output FIFO draining OUT writes.
module io_port_unit
  import io_pkg::*;
#(
  parameter int unsigned DATA_W    = io_pkg::DATA_W,
  parameter int unsigned IN_DEPTH  = 4,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           ext_in_data,
  input  logic                        ext_in_valid,
  output logic                        ext_in_ready,
  output logic [DATA_W-1:0]           in_port,
  output logic                        in_empty,
  input  logic                        in_read,
  input  logic                        out_we,
  input  logic [DATA_W-1:0]           out_port,
  output logic [DATA_W-1:0]           ext_out_data,
  output logic                        ext_out_valid,
  input  logic                        ext_out_ready,
  output logic [cntW(IN_DEPTH)-1:0]   in_count,
  output logic [cntW(OUT_DEPTH)-1:0]  out_count,
  output logic                        in_underflow,
  output logic                        out_overflow
);

  logic [DATA_W-1:0] inHead;
  logic [DATA_W-1:0] inLast;
  logic              inFull;
  logic              inEmpty;
  logic              inPush;
  logic              inPop;

  logic [DATA_W-1:0] outHead;
  logic [DATA_W-1:0] outLast;
  logic              outFull;
  logic              outEmpty;
  logic              outPop;

  always_comb begin
    ext_in_ready  = !inFull;
    inPush        = ext_in_valid && !inFull;
    inPop         = in_read && !inEmpty;
    in_empty      = inEmpty;
    // When drained, the ports keep showing the last word handed over (0 after reset).
    in_port       = inEmpty ? inLast : inHead;
    ext_out_valid = !outEmpty;
    ext_out_data  = outEmpty ? outLast : outHead;
    outPop        = !outEmpty && ext_out_ready;
  end

  port_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (IN_DEPTH)
  ) inFifo (
    .clk        (clk),
    .reset      (reset),
    .push       (inPush),
    .pop        (inPop),
    .dataIn     (ext_in_data),
    .head       (inHead),
    .lastPopped (inLast),
    .count      (in_count),
    .full       (inFull),
    .empty      (inEmpty)
  );

  port_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (OUT_DEPTH)
  ) outFifo (
    .clk        (clk),
    .reset      (reset),
    .push       (out_we),
    .pop        (outPop),
    .dataIn     (out_port),
    .head       (outHead),
    .lastPopped (outLast),
    .count      (out_count),
    .full       (outFull),
    .empty      (outEmpty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      in_underflow <= 1'b0;
      out_overflow <= 1'b0;
    end else begin
      if (in_read && inEmpty) begin
        in_underflow <= 1'b1;
      end
      if (out_we && outFull && !outPop) begin
        out_overflow <= 1'b1;
      end
    end
  end

endmodule
